// File: rtl/clock_pkg.sv
// Shared BCD constants and helpers for the timebase consumer blocks.
package clock_pkg;

    localparam logic [7:0] BCD_59    = 8'h59;
    localparam logic [7:0] BCD_ZERO  = 8'h00;
    localparam logic [3:0] DIGIT_MAX = 4'h9;

    // Returns {wrap, next}: wraps to zero once the value has reached limit.
    function automatic logic [8:0] bcd_inc(input logic [7:0] value, input logic [7:0] limit);
        logic [8:0] result;
        if (value >= limit) begin
            result = {1'b1, BCD_ZERO};
        end else if (value[3:0] >= DIGIT_MAX) begin
            result = {1'b0, value[7:4] + 4'h1, 4'h0};
        end else begin
            result = {1'b0, value[7:4], value[3:0] + 4'h1};
        end
        return result;
    endfunction

    function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] limit);
        return (value[7:4] <= DIGIT_MAX) && (value[3:0] <= DIGIT_MAX) && (value <= limit);
    endfunction

endpackage

// File: rtl/tick_sync.sv
// Resynchronises the divided slow clock into clk and emits a one-cycle tick per rising edge.
module tick_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick_clk,
    output logic o_tick
);

    localparam int              ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [ARM_W-1:0]       r_arm_cnt;
    logic                   w_armed;

    // Synchroniser chain, edge history, and post-reset arming counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync    <= '0;
            r_prev    <= 1'b0;
            r_arm_cnt <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_tick_clk};
            r_prev <= r_sync[SYNC_STAGES-1];
            if (r_arm_cnt != ARM_DONE) begin
                r_arm_cnt <= r_arm_cnt + ARM_W'(1);
            end else begin
                r_arm_cnt <= r_arm_cnt;
            end
        end
    end

    // A level already high at reset release reaches r_prev before arming completes.
    assign w_armed = (r_arm_cnt == ARM_DONE);
    assign o_tick  = w_armed & r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/time_keeper.sv
// 24-hour BCD hh:mm:ss counter driven by ticks from the divided timebase, with validated loading.
module time_keeper
    import clock_pkg::*;
#(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] MAX_HOUR_BCD = 8'h23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick_clk,
    input  logic       i_hold,
    input  logic       i_load,
    input  logic [7:0] i_load_hh,
    input  logic [7:0] i_load_mm,
    input  logic [7:0] i_load_ss,
    output logic [7:0] o_hh,
    output logic [7:0] o_mm,
    output logic [7:0] o_ss,
    output logic       o_sec_pulse,
    output logic       o_min_carry,
    output logic       o_day_carry,
    output logic       o_load_ack,
    output logic       o_load_err
);

    logic       w_tick;
    logic       w_load_ok;
    logic [8:0] w_ss_inc;
    logic [8:0] w_mm_inc;
    logic [8:0] w_hh_inc;
    logic [7:0] w_hh_nx, w_mm_nx, w_ss_nx;
    logic       w_sec_nx, w_min_nx, w_day_nx, w_ack_nx, w_err_nx;
    logic [7:0] r_hh, r_mm, r_ss;
    logic       r_sec, r_min, r_day, r_ack, r_err;

    tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
        .clk        (clk),
        .rst        (rst),
        .i_tick_clk (i_tick_clk),
        .o_tick     (w_tick)
    );

    assign w_load_ok = bcd_valid(i_load_hh, MAX_HOUR_BCD) &&
                       bcd_valid(i_load_mm, BCD_59) &&
                       bcd_valid(i_load_ss, BCD_59);
    assign w_ss_inc  = bcd_inc(r_ss, BCD_59);
    assign w_mm_inc  = bcd_inc(r_mm, BCD_59);
    assign w_hh_inc  = bcd_inc(r_hh, MAX_HOUR_BCD);

    // Next-state: load beats tick; carries ripple through all fields in one cycle.
    always_comb begin
        w_hh_nx  = r_hh;
        w_mm_nx  = r_mm;
        w_ss_nx  = r_ss;
        w_sec_nx = 1'b0;
        w_min_nx = 1'b0;
        w_day_nx = 1'b0;
        w_ack_nx = 1'b0;
        w_err_nx = 1'b0;
        if (i_load) begin
            if (w_load_ok) begin
                w_hh_nx  = i_load_hh;
                w_mm_nx  = i_load_mm;
                w_ss_nx  = i_load_ss;
                w_ack_nx = 1'b1;
            end else begin
                w_err_nx = 1'b1;
            end
        end else if (w_tick && !i_hold) begin
            w_ss_nx  = w_ss_inc[7:0];
            w_sec_nx = 1'b1;
            if (w_ss_inc[8]) begin
                w_min_nx = 1'b1;
                w_mm_nx  = w_mm_inc[7:0];
                if (w_mm_inc[8]) begin
                    w_hh_nx  = w_hh_inc[7:0];
                    w_day_nx = w_hh_inc[8];
                end else begin
                    w_hh_nx = r_hh;
                end
            end else begin
                w_mm_nx = r_mm;
            end
        end else begin
            w_ss_nx = r_ss;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hh  <= 8'h00;
            r_mm  <= 8'h00;
            r_ss  <= 8'h00;
            r_sec <= 1'b0;
            r_min <= 1'b0;
            r_day <= 1'b0;
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_hh  <= w_hh_nx;
            r_mm  <= w_mm_nx;
            r_ss  <= w_ss_nx;
            r_sec <= w_sec_nx;
            r_min <= w_min_nx;
            r_day <= w_day_nx;
            r_ack <= w_ack_nx;
            r_err <= w_err_nx;
        end
    end

    assign o_hh        = r_hh;
    assign o_mm        = r_mm;
    assign o_ss        = r_ss;
    assign o_sec_pulse = r_sec;
    assign o_min_carry = r_min;
    assign o_day_carry = r_day;
    assign o_load_ack  = r_ack;
    assign o_load_err  = r_err;

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper; reference model keeps time as seconds-of-day.
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_clk = 1'b0;
    logic       hold = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_hh = 8'h00, load_mm = 8'h00, load_ss = 8'h00;
    logic [7:0] hh, mm, ss;
    logic       sec_pulse, min_carry, day_carry, load_ack, load_err;

    int checks = 0;
    int failures = 0;

    int ref_secs = 0;
    bit exp_sec = 1'b0, exp_min = 1'b0, exp_day = 1'b0, exp_ack = 1'b0, exp_err = 1'b0;

    time_keeper dut (
        .clk         (clk),
        .rst         (rst),
        .i_tick_clk  (tick_clk),
        .i_hold      (hold),
        .i_load      (load),
        .i_load_hh   (load_hh),
        .i_load_mm   (load_mm),
        .i_load_ss   (load_ss),
        .o_hh        (hh),
        .o_mm        (mm),
        .o_ss        (ss),
        .o_sec_pulse (sec_pulse),
        .o_min_carry (min_carry),
        .o_day_carry (day_carry),
        .o_load_ack  (load_ack),
        .o_load_err  (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    // A BCD byte is legal if both digits are decimal and its decimal value is within max.
    function automatic bit field_ok(input logic [7:0] b, input int max);
        int hi, lo;
        hi = int'(b[7:4]);
        lo = int'(b[3:0]);
        return (hi <= 9) && (lo <= 9) && (hi * 10 + lo <= max);
    endfunction

    function automatic int bcd_val(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".hh"}, hh, to_bcd(ref_secs / 3600));
        chk({tag, ".mm"}, mm, to_bcd((ref_secs / 60) % 60));
        chk({tag, ".ss"}, ss, to_bcd(ref_secs % 60));
        chk({tag, ".sec_pulse"}, {7'd0, sec_pulse}, {7'd0, exp_sec});
        chk({tag, ".min_carry"}, {7'd0, min_carry}, {7'd0, exp_min});
        chk({tag, ".day_carry"}, {7'd0, day_carry}, {7'd0, exp_day});
        chk({tag, ".load_ack"}, {7'd0, load_ack}, {7'd0, exp_ack});
        chk({tag, ".load_err"}, {7'd0, load_err}, {7'd0, exp_err});
    endtask

    task automatic clear_exp();
        exp_sec = 1'b0; exp_min = 1'b0; exp_day = 1'b0; exp_ack = 1'b0; exp_err = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        if (field_ok(h, 23) && field_ok(m, 59) && field_ok(s, 59)) begin
            ref_secs = bcd_val(h) * 3600 + bcd_val(m) * 60 + bcd_val(s);
            exp_ack  = 1'b1;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic model_tick();
        ref_secs = (ref_secs + 1) % 86400;
        exp_sec  = 1'b1;
        exp_min  = (ref_secs % 60) == 0;
        exp_day  = (ref_secs == 0);
    endtask

    task automatic do_load(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        load = 1'b1; load_hh = h; load_mm = m; load_ss = s;
        step();
        load = 1'b0;
        model_load(h, m, s);
        check_all(tag);
        clear_exp();
        step();
        check_all({tag, ".after"});
    endtask

    // Rising tick_clk; the tick lands on the 3rd clk edge, optionally colliding with a load.
    task automatic do_tick(input string tag, input bit with_load,
                           input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        tick_clk = 1'b1;
        step();
        check_all({tag, ".e1"});
        step();
        check_all({tag, ".e2"});
        if (with_load) begin
            load = 1'b1; load_hh = h; load_mm = m; load_ss = s;
        end
        step();
        load = 1'b0;
        if (with_load) model_load(h, m, s);
        else if (!hold) model_tick();
        check_all({tag, ".e3"});
        clear_exp();
        step();
        check_all({tag, ".e4"});
        step();
        tick_clk = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        logic [7:0] rh, rm, rs;
        int         n;

        // Reset with tick_clk already high: no tick may follow release.
        tick_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_all("arm_high");
        end
        tick_clk = 1'b0;
        repeat (4) step();

        do_tick("first_tick", 1'b0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 9; i++) do_tick("count10", 1'b0, 8'h00, 8'h00, 8'h00);
        chk("ss_after_10", ss, 8'h10);

        do_load("load_235958", 8'h23, 8'h59, 8'h58);
        do_tick("to_235959", 1'b0, 8'h00, 8'h00, 8'h00);
        do_tick("day_wrap", 1'b0, 8'h00, 8'h00, 8'h00);
        chk("wrap_hh", hh, 8'h00);

        do_load("bad_hh24", 8'h24, 8'h00, 8'h00);
        do_load("bad_mm5A", 8'h01, 8'h5A, 8'h00);
        do_load("bad_ssA0", 8'h01, 8'h00, 8'hA0);
        do_load("load_123456", 8'h12, 8'h34, 8'h56);
        chk("ld_hh", hh, 8'h12);

        do_tick("load_in_tick", 1'b1, 8'h00, 8'h00, 8'h05);
        do_tick("after_collide", 1'b0, 8'h00, 8'h00, 8'h00);
        do_tick("bad_load_in_tick", 1'b1, 8'h30, 8'h00, 8'h00);

        hold = 1'b1;
        for (int i = 0; i < 3; i++) do_tick("held", 1'b0, 8'h00, 8'h00, 8'h00);
        do_load("load_in_hold", 8'h00, 8'h59, 8'h59);
        hold = 1'b0;
        do_tick("unheld", 1'b0, 8'h00, 8'h00, 8'h00);

        // Back-to-back loads, one per cycle.
        load = 1'b1; load_hh = 8'h05; load_mm = 8'h06; load_ss = 8'h07;
        step();
        model_load(8'h05, 8'h06, 8'h07);
        check_all("b2b_1");
        clear_exp();
        load_hh = 8'h1F;
        step();
        load = 1'b0;
        model_load(8'h1F, 8'h06, 8'h07);
        check_all("b2b_2");
        clear_exp();

        // Randomised loads, ticks, holds and collisions.
        for (int it = 0; it < 30; it++) begin
            n = int'($urandom_range(0, 3));
            if (n == 0) begin
                rh = 8'($urandom); rm = 8'($urandom); rs = 8'($urandom);
                do_load("rnd_raw", rh, rm, rs);
            end else if (n == 1) begin
                rh = to_bcd(int'($urandom_range(22, 23)));
                rm = to_bcd(int'($urandom_range(58, 59)));
                rs = to_bcd(int'($urandom_range(57, 59)));
                do_load("rnd_edge", rh, rm, rs);
            end else begin
                rh = 8'h00;
            end
            hold = ($urandom_range(0, 3) == 0);
            n = int'($urandom_range(1, 4));
            for (int t = 0; t < n; t++) begin
                if ($urandom_range(0, 7) == 0) begin
                    rh = to_bcd(int'($urandom_range(0, 23)));
                    rm = to_bcd(int'($urandom_range(0, 59)));
                    rs = to_bcd(int'($urandom_range(0, 59)));
                    do_tick("rnd_collide", 1'b1, rh, rm, rs);
                end else begin
                    do_tick("rnd_tick", 1'b0, 8'h00, 8'h00, 8'h00);
                end
            end
            hold = 1'b0;
        end

        // Asynchronous reset in the middle of counting.
        do_load("load_070809", 8'h07, 8'h08, 8'h09);
        do_tick("pre_rst", 1'b0, 8'h00, 8'h00, 8'h00);
        rst = 1'b0;
        #1;
        ref_secs = 0;
        clear_exp();
        check_all("async_rst");
        step();
        check_all("rst_held");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
